// File: rtl/serial_link_if.sv
// Parallel/serial signal bundle for serial_link.
// master = the user of the link, slave = the serial_link core.
interface serial_link_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D_in;
  logic             send;
  logic             busy;
  logic             o_clk;
  logic             o_data;
  logic             o_strobe;
  logic             i_clk;
  logic             i_data;
  logic             i_strobe;
  logic [WIDTH-1:0] D_out;
  logic             valid;
  logic             parity_err;
  logic             frame_err;

  modport master (
    output D_in, send, i_clk, i_data, i_strobe,
    input  busy, o_clk, o_data, o_strobe, D_out, valid, parity_err, frame_err
  );

  modport slave (
    input  D_in, send, i_clk, i_data, i_strobe,
    output busy, o_clk, o_data, o_strobe, D_out, valid, parity_err, frame_err
  );
endinterface

// File: rtl/serial_link.sv
// Strobed serial link: framed TX serializer with divided bit clock and
// same-domain RX deserializer with bit-count and even-parity checking.
module serial_link #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1,
  parameter int PARITY_EN = 0
) (
  input  logic        sys_clk,
  input  logic        i_rst,
  serial_link_if.slave bus
);
  localparam int NBITS = WIDTH + PARITY_EN;
  localparam int PH_W  = $clog2(2 * DIV);
  localparam int BC_W  = $clog2(NBITS + 2);

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(2 * DIV - 1);
  localparam logic [PH_W-1:0] PH_HI    = PH_W'(DIV);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(NBITS - 1);
  localparam logic [BC_W-1:0] CNT_FULL = BC_W'(NBITS);
  localparam logic [BC_W-1:0] CNT_SAT  = BC_W'(NBITS + 1);
  localparam logic [BC_W-1:0] WIDTH_C  = BC_W'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_e;

  function automatic logic [BC_W-1:0] sat_inc(input logic [BC_W-1:0] c);
    return (c == CNT_SAT) ? c : c + BC_W'(1);
  endfunction

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
  logic             tx_par_q, tx_par_d;
  logic [BC_W-1:0]  bit_q, bit_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic             cur_bit;

  always_ff @(posedge sys_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
    tx_sh_q  <= tx_sh_d;
    tx_par_q <= tx_par_d;
    bit_q    <= bit_d;
    ph_q     <= ph_d;
  end

  always_comb begin
    state_d  = state_q;
    tx_sh_d  = tx_sh_q;
    tx_par_d = tx_par_q;
    bit_d    = bit_q;
    ph_d     = ph_q;
    case (state_q)
      IDLE: begin
        if (bus.send) begin
          state_d  = SHIFT;
          tx_sh_d  = bus.D_in;
          tx_par_d = ^bus.D_in;
          bit_d    = '0;
          ph_d     = '0;
        end
      end
      SHIFT: begin
        if (ph_q == PH_LAST) begin
          ph_d = '0;
          // Shift register exposes the next payload bit at a fixed end.
          if (MSB_FIRST != 0) tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
          else                tx_sh_d = {1'b0, tx_sh_q[WIDTH-1:1]};
          if (bit_q == BIT_LAST) state_d = GAP;
          else                   bit_d   = bit_q + BC_W'(1);
        end else begin
          ph_d = ph_q + PH_W'(1);
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (bit_q < WIDTH_C) cur_bit = (MSB_FIRST != 0) ? tx_sh_q[WIDTH-1] : tx_sh_q[0];
    else                 cur_bit = tx_par_q;
  end

  always_comb begin
    bus.busy     = 1'b0;
    bus.o_strobe = 1'b0;
    bus.o_clk    = 1'b0;
    bus.o_data   = 1'b0;
    case (state_q)
      SHIFT: begin
        bus.busy     = 1'b1;
        bus.o_strobe = 1'b1;
        bus.o_clk    = (ph_q >= PH_HI);
        bus.o_data   = cur_bit;
      end
      GAP:     bus.busy = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  logic             clk_prev_q, stb_prev_q;
  logic [BC_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] pay_q, pay_d;
  logic             rpar_q, rpar_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d;
  logic             rise, fall;

  assign rise = bus.i_clk & ~clk_prev_q;
  assign fall = stb_prev_q & ~bus.i_strobe;

  always_comb begin
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    rpar_d  = rpar_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    perr_d  = 1'b0;
    ferr_d  = 1'b0;
    if (!bus.i_strobe) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = sat_inc(cnt_q);
      if (cnt_q < WIDTH_C) begin
        if (MSB_FIRST != 0) pay_d = {pay_q[WIDTH-2:0], bus.i_data};
        else                pay_d = {bus.i_data, pay_q[WIDTH-1:1]};
      end
      if (cnt_q == WIDTH_C) rpar_d = bus.i_data;
    end
    if (fall) begin
      if (cnt_q == CNT_FULL) begin
        dout_d  = pay_q;
        valid_d = 1'b1;
        perr_d  = (PARITY_EN != 0) && ((^pay_q) != rpar_q);
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (i_rst) begin
      clk_prev_q <= 1'b0;
      stb_prev_q <= 1'b0;
      cnt_q      <= '0;
      dout_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      clk_prev_q <= bus.i_clk;
      stb_prev_q <= bus.i_strobe;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
    pay_q  <= pay_d;
    rpar_q <= rpar_d;
  end

  assign bus.D_out      = dout_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
endmodule

// File: tb/tb_serial_link.sv
// Bench for serial_link: three configurations (8/1/MSB, 8/1/MSB+parity,
// 8/3/LSB) in loopback or with bench-driven RX frames.
module tb_serial_link;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       send_r [3];
  logic [7:0] din_r  [3];
  logic       lb     [3];
  logic       mclk   [3];
  logic       mdat   [3];
  logic       mstb   [3];

  logic       busy_w [3];
  logic       oclk_w [3];
  logic       odat_w [3];
  logic       ostb_w [3];
  logic       vld_w  [3];
  logic       perr_w [3];
  logic       ferr_w [3];
  logic [7:0] dout_w [3];

  int checks = 0;
  int errors = 0;

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      serial_link_if #(.WIDTH(8)) ifc ();
      serial_link #(
        .WIDTH(8),
        .DIV(g == 2 ? 3 : 1),
        .MSB_FIRST(g == 2 ? 0 : 1),
        .PARITY_EN(g == 1 ? 1 : 0)
      ) u_dut (
        .sys_clk(clk),
        .i_rst(rst),
        .bus(ifc.slave)
      );
      assign ifc.D_in     = din_r[g];
      assign ifc.send     = send_r[g];
      assign ifc.i_clk    = lb[g] ? ifc.o_clk    : mclk[g];
      assign ifc.i_data   = lb[g] ? ifc.o_data   : mdat[g];
      assign ifc.i_strobe = lb[g] ? ifc.o_strobe : mstb[g];
      assign busy_w[g] = ifc.busy;
      assign oclk_w[g] = ifc.o_clk;
      assign odat_w[g] = ifc.o_data;
      assign ostb_w[g] = ifc.o_strobe;
      assign vld_w[g]  = ifc.valid;
      assign perr_w[g] = ifc.parity_err;
      assign ferr_w[g] = ifc.frame_err;
      assign dout_w[g] = ifc.D_out;
    end
  endgenerate

  function automatic int divk(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  function automatic int nbk(input int k);
    return (k == 1) ? 9 : 8;
  endfunction

  // Wire order of a frame: element i is the i-th bit transmitted.
  function automatic logic [8:0] exp_bits(input int k, input logic [7:0] v);
    logic [8:0] b;
    for (int i = 0; i < 8; i++) b[i] = (k == 2) ? v[i] : v[7 - i];
    b[8] = ^v;
    return b;
  endfunction

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic run_frame(input int k, input logic [7:0] v, input bit inject, input string tag);
    int cyc, nbusy, nrise, nvld, nperr, nferr, last_hi, vld_at, r0, r1, idle, nb, dv;
    logic [8:0] got;
    logic [7:0] dcap;
    logic prev;
    nb = nbk(k);
    dv = divk(k);
    @(negedge clk);
    din_r[k]  = v;
    send_r[k] = 1'b1;
    @(negedge clk);
    send_r[k] = 1'b0;
    cyc = 0; nbusy = 0; nrise = 0; nvld = 0; nperr = 0; nferr = 0;
    last_hi = -100; vld_at = -1; r0 = -1; r1 = -1; idle = 0;
    got = '0; dcap = 8'h00; prev = 1'b0;
    while (idle < 6 && cyc < 2000) begin
      if (inject && cyc == 3) begin
        send_r[k] = 1'b1;
        din_r[k]  = ~v;
      end
      if (inject && cyc == 5) send_r[k] = 1'b0;
      if (busy_w[k]) nbusy++;
      if (oclk_w[k] && !prev) begin
        if (nrise < 9) got[nrise] = odat_w[k];
        if (nrise == 0) r0 = cyc;
        if (nrise == 1) r1 = cyc;
        nrise++;
      end
      if (oclk_w[k]) last_hi = cyc;
      if (vld_w[k]) begin
        nvld++;
        vld_at = cyc;
        dcap   = dout_w[k];
      end
      if (perr_w[k]) nperr++;
      if (ferr_w[k]) nferr++;
      if (!busy_w[k] && nbusy > 0) idle++;
      prev = oclk_w[k];
      cyc++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, nbusy, 2 * dv * nb + 1);
    chk({tag, " bit_count"}, nrise, nb);
    chk({tag, " bits"}, int'(got) & ((1 << nb) - 1), int'(exp_bits(k, v)) & ((1 << nb) - 1));
    chk({tag, " clk_period"}, r1 - r0, 2 * dv);
    chk({tag, " valid_pulses"}, nvld, 1);
    chk({tag, " d_out"}, int'(dcap), int'(v));
    chk({tag, " valid_latency"}, vld_at - last_hi, 2);
    chk({tag, " parity_err"}, nperr, 0);
    chk({tag, " frame_err"}, nferr, 0);
  endtask

  task automatic drive_frame(input int k, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mstb[k] = 1'b1;
      mdat[k] = bits[i];
      mclk[k] = 1'b0;
      @(negedge clk);
      mclk[k] = 1'b1;
    end
    @(negedge clk);
    mclk[k] = 1'b0;
    mstb[k] = 1'b0;
  endtask

  task automatic collect(input int k, input int n, output int nv, output int np,
                         output int nf, output logic [7:0] d);
    nv = 0; np = 0; nf = 0; d = dout_w[k];
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (vld_w[k]) begin
        nv++;
        d = dout_w[k];
      end
      if (perr_w[k]) np++;
      if (ferr_w[k]) nf++;
    end
  endtask

  initial begin
    int nv, np, nf, nr, cyc;
    logic [7:0] d, prevd, rv;
    logic [15:0] fb;
    logic prev;

    for (int i = 0; i < 3; i++) begin
      send_r[i] = 1'b0; din_r[i] = 8'h00; lb[i] = 1'b1;
      mclk[i] = 1'b0; mdat[i] = 1'b0; mstb[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset%0d busy", k), int'(busy_w[k]), 0);
      chk($sformatf("reset%0d serial_out", k), int'({oclk_w[k], odat_w[k], ostb_w[k]}), 0);
      chk($sformatf("reset%0d d_out", k), int'(dout_w[k]), 0);
      chk($sformatf("reset%0d flags", k), int'({vld_w[k], perr_w[k], ferr_w[k]}), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_frame(0, 8'hFA, 1'b0, "fa_msb");
    run_frame(0, 8'hD4, 1'b1, "d4_busy_send");
    run_frame(1, 8'hD4, 1'b0, "d4_parity");
    run_frame(2, 8'h01, 1'b0, "01_lsb_div3");

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 3; k++) begin
        rv = 8'($urandom);
        run_frame(k, rv, 1'b0, $sformatf("rand%0d_cfg%0d", r, k));
      end
    end

    // Parity bit inverted on the wire: payload still delivered, error flagged.
    @(negedge clk);
    lb[1] = 1'b0;
    fb = 16'(exp_bits(1, 8'hD4)) ^ 16'h0100;
    drive_frame(1, fb, 9);
    collect(1, 6, nv, np, nf, d);
    chk("flip_parity valid", nv, 1);
    chk("flip_parity parity_err", np, 1);
    chk("flip_parity d_out", int'(d), 8'hD4);
    chk("flip_parity frame_err", nf, 0);

    @(negedge clk);
    lb[0] = 1'b0;
    prevd = dout_w[0];
    drive_frame(0, 16'h0015, 5);
    collect(0, 6, nv, np, nf, d);
    chk("short_frame frame_err", nf, 1);
    chk("short_frame valid", nv, 0);
    chk("short_frame d_out", int'(dout_w[0]), int'(prevd));

    drive_frame(0, 16'h02A5, 10);
    collect(0, 6, nv, np, nf, d);
    chk("long_frame frame_err", nf, 1);
    chk("long_frame valid", nv, 0);
    chk("long_frame d_out", int'(dout_w[0]), int'(prevd));

    fb = 16'(exp_bits(0, 8'h6C));
    drive_frame(0, fb, 8);
    collect(0, 6, nv, np, nf, d);
    chk("manual_frame valid", nv, 1);
    chk("manual_frame d_out", int'(d), 8'h6C);
    chk("manual_frame frame_err", nf, 0);

    // Abort a loopback frame after three bits have gone out.
    @(negedge clk);
    lb[0] = 1'b1;
    @(negedge clk);
    din_r[0]  = 8'h3C;
    send_r[0] = 1'b1;
    @(negedge clk);
    send_r[0] = 1'b0;
    nr = 0; cyc = 0; prev = 1'b0;
    while (nr < 3 && cyc < 200) begin
      if (oclk_w[0] && !prev) nr++;
      prev = oclk_w[0];
      cyc++;
      @(negedge clk);
    end
    chk("abort three_bits_seen", nr, 3);
    rst       = 1'b1;
    send_r[0] = 1'b1;
    @(negedge clk);
    chk("abort busy", int'(busy_w[0]), 0);
    chk("abort strobe", int'(ostb_w[0]), 0);
    chk("abort d_out", int'(dout_w[0]), 0);
    @(negedge clk);
    chk("abort send_in_reset", int'(busy_w[0]), 0);
    rst       = 1'b0;
    send_r[0] = 1'b0;
    collect(0, 8, nv, np, nf, d);
    chk("abort valid", nv, 0);
    chk("abort frame_err", nf, 0);
    chk("abort idle", int'(busy_w[0]), 0);
    run_frame(0, 8'h5B, 1'b0, "after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
